// File: rtl/Modules_pkg.sv
// Shared definitions for the integer execute-stage functional units.
//   XLEN       : datapath width
//   div_ops_e  : RV32M division group operation select
//   fu_state_e : functional-unit occupancy reported to issue logic
package Modules_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_  = 2'b00,
        DIVU_ = 2'b01,
        REM_  = 2'b10,
        REMU_ = 2'b11
    } div_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;

endpackage

// File: rtl/mgt_01_div_unit.sv
// mgt_01_div_unit
// Iterative radix-2 restoring divider for DIV / DIVU / REM / REMU.
// One operation in flight; 32 iteration cycles between accept and result.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   clk_en_i     clock enable; every register holds while low
//   valid_i      start request, taken only while the unit reports FREE
//   dividend_i   rs1 operand (XLEN)
//   divisor_i    rs2 operand (XLEN)
//   operation_i  DIV_, DIVU_, REM_, REMU_
//   result_o     registered result, held until the next completion
//   valid_o      one-enabled-cycle result strobe
//   fu_state_o   BUSY while iterating, FREE otherwise
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed-overflow
//                     operations bypass the iteration and complete on the
//                     accept edge. When undefined they iterate normally and
//                     produce the same special results after 32 cycles.
module mgt_01_div_unit
    import Modules_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  div_ops_e        operation_i,
    output logic [XLEN-1:0] result_o,
    output logic            valid_o,
    output fu_state_e       fu_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIVIDE = 2'b01,
        DONE   = 2'b10
    } state_e;

    state_e state_reg, state_next;

    // Operation context captured at accept
    logic            is_rem_reg;
    logic            neg_quo_reg;
    logic            neg_rem_reg;
    logic            zero_reg;
    logic            ovf_reg;
    logic [XLEN-1:0] dividend_reg;     // raw rs1, needed for REM by zero
    logic [XLEN-1:0] divisor_mag_reg;

    // Iteration datapath
    logic [XLEN:0]   rem_reg;          // partial remainder, one guard bit
    logic [XLEN-1:0] quo_reg;          // starts as |dividend|, fills with quotient bits
    logic [4:0]      count_reg;

    logic [XLEN-1:0] result_reg;
    logic            valid_reg;

    // ------------------------------------------------------------------
    // Accept-time operand decode
    // ------------------------------------------------------------------
    logic            is_signed_in;
    logic            is_rem_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic            zero_in;
    logic            ovf_in;
    logic            accept;

    always_comb begin
        is_signed_in = (operation_i == DIV_) || (operation_i == REM_);
        is_rem_in    = (operation_i == REM_) || (operation_i == REMU_);
        a_neg_in     = is_signed_in && dividend_i[XLEN-1];
        b_neg_in     = is_signed_in && divisor_i[XLEN-1];
        // -0x80000000 wraps to itself, which is still the correct unsigned magnitude
        a_mag_in     = a_neg_in ? (~dividend_i + 1'b1) : dividend_i;
        b_mag_in     = b_neg_in ? (~divisor_i + 1'b1) : divisor_i;
        zero_in      = (divisor_i == '0);
        ovf_in       = is_signed_in
                       && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                       && (divisor_i == '1);
    end

    assign accept = valid_i && ((state_reg == IDLE) || (state_reg == DONE));

`ifdef DIV_EARLY_OUT_EN
    logic special_in;
    assign special_in = zero_in || ovf_in;
`endif

    // Results that bypass the iteration outcome: divide by zero returns
    // all-ones (quotient) or the dividend (remainder); signed overflow
    // returns the most negative value (quotient) or zero (remainder).
    function automatic logic [XLEN-1:0] special_result(
        input logic            is_rem,
        input logic            zero,
        input logic [XLEN-1:0] dividend
    );
        logic [XLEN-1:0] res;
        if (zero) begin
            res = is_rem ? dividend : '1;
        end else begin
            res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [XLEN+1:0] shift_rem;
    logic [XLEN+1:0] trial;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_signed;
    logic [XLEN-1:0] rem_signed;
    logic [XLEN-1:0] final_result;

    always_comb begin
        shift_rem  = {rem_reg, quo_reg[XLEN-1]};
        trial      = shift_rem - {2'b00, divisor_mag_reg};
        // trial MSB set means the subtraction went negative: keep the shifted value
        step_rem   = trial[XLEN+1] ? shift_rem[XLEN:0] : trial[XLEN:0];
        step_quo   = {quo_reg[XLEN-2:0], ~trial[XLEN+1]};
        quo_signed = neg_quo_reg ? (~step_quo + 1'b1) : step_quo;
        rem_signed = neg_rem_reg ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
        if (zero_reg || ovf_reg) begin
            final_result = special_result(is_rem_reg, zero_reg, dividend_reg);
        end else begin
            final_result = is_rem_reg ? rem_signed : quo_signed;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
        end else if (clk_en_i) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (valid_i) begin
`ifdef DIV_EARLY_OUT_EN
                    state_next = special_in ? DONE : DIVIDE;
`else
                    state_next = DIVIDE;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            DIVIDE: begin
                if (count_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            is_rem_reg      <= 1'b0;
            neg_quo_reg     <= 1'b0;
            neg_rem_reg     <= 1'b0;
            zero_reg        <= 1'b0;
            ovf_reg         <= 1'b0;
            dividend_reg    <= '0;
            divisor_mag_reg <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            count_reg       <= '0;
            result_reg      <= '0;
            valid_reg       <= 1'b0;
        end else if (clk_en_i) begin
            // Strobe lasts exactly one enabled cycle unless re-asserted below
            valid_reg <= 1'b0;
            if (accept) begin
                is_rem_reg      <= is_rem_in;
                neg_quo_reg     <= a_neg_in ^ b_neg_in;
                neg_rem_reg     <= a_neg_in;
                zero_reg        <= zero_in;
                ovf_reg         <= ovf_in;
                dividend_reg    <= dividend_i;
                divisor_mag_reg <= b_mag_in;
                rem_reg         <= '0;
                quo_reg         <= a_mag_in;
                count_reg       <= '0;
`ifdef DIV_EARLY_OUT_EN
                if (special_in) begin
                    result_reg <= special_result(is_rem_in, zero_in, dividend_i);
                    valid_reg  <= 1'b1;
                end
`endif
            end else if (state_reg == DIVIDE) begin
                rem_reg <= step_rem;
                quo_reg <= step_quo;
                if (count_reg == 5'd31) begin
                    result_reg <= final_result;
                    valid_reg  <= 1'b1;
                end else begin
                    count_reg <= count_reg + 5'd1;
                end
            end
        end
    end

    assign result_o   = result_reg;
    assign valid_o    = valid_reg;
    assign fu_state_o = (state_reg == DIVIDE) ? BUSY : FREE;

endmodule

// File: tb/tb_mgt_01_div_unit.sv
module tb_mgt_01_div_unit;
    import Modules_pkg::*;

    logic        clk_i;
    logic        rst_n_i;
    logic        clk_en_i;
    logic        valid_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    div_ops_e    operation_i;
    logic [31:0] result_o;
    logic        valid_o;
    fu_state_e   fu_state_o;

    mgt_01_div_unit dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clk_en_i    (clk_en_i),
        .valid_i     (valid_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .operation_i (operation_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .fu_state_o  (fu_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        int          en_at;
        int          cyc_at;
        int          en_lat;
        int          cyc_lat;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int cmp_cnt  = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    bit last_en  = 1'b0;
    int n_issued = 0;

    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        if (clk_en_i) en_cnt <= en_cnt + 1;
        last_en <= clk_en_i;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Behavioural reference using the language's own signed/unsigned arithmetic
    function automatic logic [31:0] ref_div(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sd;
        logic ovf;
        sa  = a;
        sd  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            DIVU_:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU_:   return (b == 0) ? a : a % b;
            DIV_:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sd));
            default: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sd));
        endcase
    endfunction

    function automatic logic is_special(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (((op == DIV_) || (op == REM_)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    endfunction

    function automatic int exp_busy(input div_ops_e op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        return is_special(op, a, b) ? 0 : 32;
`else
        return (op == op && a == a && b == b) ? 32 : 32;
`endif
    endfunction

    // Called at a negedge while the unit is FREE; returns just after the accept edge
    task automatic issue(input div_ops_e op, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        e.res     = ref_div(op, a, b);
        e.en_at   = en_cnt + 1;
        e.cyc_at  = cyc + 1;
        e.en_lat  = exp_busy(op, a, b);
        e.cyc_lat = e.en_lat + stall;
        e.id      = n_issued;
        n_issued++;
        exp_q.push_back(e);
        $display("issue  #%0d op=%s a=%h b=%h expect=%h", e.id, op.name(), a, b, e.res);
        operation_i = op;
        dividend_i  = a;
        divisor_i   = b;
        valid_i     = 1'b1;
        @(posedge clk_i);
    endtask

    task automatic wait_free(output int busy);
        busy = 0;
        @(negedge clk_i);
        valid_i = 1'b0;
        while (fu_state_o == BUSY) begin
            busy++;
            if (busy > 100) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL wait_free timeout: busy %0d cycles, required at most 100", busy);
                break;
            end
            @(negedge clk_i);
        end
    endtask

    // Scoreboard monitor: one result per enabled edge with valid_o high
    always @(negedge clk_i) begin
        if (rst_n_i && last_en && valid_o) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_valid: got result %h, required no result", result_o);
            end else begin
                mon_e = exp_q.pop_front();
                $display("result #%0d got=%h expect=%h en_lat=%0d cyc_lat=%0d",
                         mon_e.id, result_o, mon_e.res, en_cnt - mon_e.en_at, cyc - mon_e.cyc_at);
                check("result", result_o, mon_e.res);
                check("en_latency", 32'(en_cnt - mon_e.en_at), 32'(mon_e.en_lat));
                check("cyc_latency", 32'(cyc - mon_e.cyc_at), 32'(mon_e.cyc_lat));
            end
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 1000));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        div_ops_e op;
        logic [31:0] a;
        logic [31:0] b;

        rst_n_i     = 1'b0;
        clk_en_i    = 1'b1;
        valid_i     = 1'b0;
        dividend_i  = '0;
        divisor_i   = '0;
        operation_i = DIV_;

        repeat (3) @(negedge clk_i);
        check("reset_result", result_o, 32'h0);
        check("reset_valid", 32'(valid_o), 32'h0);
        check("reset_fu_state", 32'(fu_state_o), 32'(FREE));
        rst_n_i = 1'b1;

        // Signed divide with timing checks, then back-to-back from DONE
        wait_free(busy);
        issue(DIV_, 32'hFFFF_FFF9, 32'd2, 0);
        wait_free(busy);
        check("busy_div_m7_2", 32'(busy), 32'd32);
        issue(REM_, 32'hFFFF_FFF9, 32'd2, 0);

        wait_free(busy);
        issue(DIVU_, 32'hFFFF_FFFF, 32'd1, 0);
        wait_free(busy);
        issue(REMU_, 32'd100, 32'd7, 0);

        // Divide by zero
        wait_free(busy);
        issue(DIV_, 32'd5, 32'd0, 0);
        wait_free(busy);
        check("busy_div_by_zero", 32'(busy), 32'(exp_busy(DIV_, 32'd5, 32'd0)));
        issue(REMU_, 32'd5, 32'd0, 0);

        // Signed overflow
        wait_free(busy);
        issue(DIV_, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_free(busy);
        check("busy_overflow", 32'(busy), 32'(exp_busy(DIV_, 32'h8000_0000, 32'hFFFF_FFFF)));
        issue(REM_, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Clock-enable stall with operand churn
        wait_free(busy);
        issue(DIV_, 32'd1000, 32'd3, 5);
        repeat (5) @(negedge clk_i);
        clk_en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i     = 1'($urandom);
            dividend_i  = $urandom;
            divisor_i   = $urandom;
            operation_i = div_ops_e'(2'($urandom_range(0, 3)));
            @(negedge clk_i);
        end
        clk_en_i = 1'b1;
        valid_i  = 1'b0;
        wait_free(busy);

        // Asynchronous reset in mid-operation (counter at 10)
        issue(DIV_, 32'd1000, 32'd3, 0);
        repeat (10) @(posedge clk_i);
        #2;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check("async_rst_result", result_o, 32'h0);
        check("async_rst_valid", 32'(valid_o), 32'h0);
        check("async_rst_fu_state", 32'(fu_state_o), 32'(FREE));
        exp_q.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        wait_free(busy);
        issue(DIVU_, 32'd9, 32'd4, 0);

        // Randomized traffic with occasional idle gaps
        for (int n = 0; n < 40; n++) begin
            wait_free(busy);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(negedge clk_i);
            end
            op = div_ops_e'(2'($urandom_range(0, 3)));
            a  = rnd_operand();
            b  = rnd_operand();
            issue(op, a, b, 0);
        end

        wait_free(busy);
        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
